// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB) with imem/dmem req/ready handshake.
// Define MC_CTRL_PERF_EN to build the cycle and retired-instruction counters; otherwise they read 0.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWE,
    output logic             IRWE,
    output logic             RFWE,
    output logic             DMWE,
    output logic [2:0]       NPCOp,
    output logic [3:0]       ALUOp,
    output logic [2:0]       DMOp,
    output logic             immExtOp,
    output logic             BSel,
    output logic [1:0]       WRSel,
    output logic [1:0]       RFWDSel,
    output logic             illegal,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
    state_t state;
    logic r_type, i_add, i_sub, i_slt, i_sll, i_jr, i_ori, i_lui;
    logic i_lw, i_lb, i_lbu, i_sw, i_sb, i_beq, i_j, i_jal;
    logic load, store, alu_r, known, dec_jump;
    always_comb begin
        r_type   = opcode == 6'h00;
        i_add    = r_type && funct == 6'h20;
        i_sub    = r_type && funct == 6'h22;
        i_slt    = r_type && funct == 6'h2a;
        i_sll    = r_type && funct == 6'h00;
        i_jr     = r_type && funct == 6'h08;
        i_ori    = opcode == 6'h0d;
        i_lui    = opcode == 6'h0f;
        i_lw     = opcode == 6'h23;
        i_lb     = opcode == 6'h20;
        i_lbu    = opcode == 6'h24;
        i_sw     = opcode == 6'h2b;
        i_sb     = opcode == 6'h28;
        i_beq    = opcode == 6'h04;
        i_j      = opcode == 6'h02;
        i_jal    = opcode == 6'h03;
        load     = i_lw | i_lb | i_lbu;
        store    = i_sw | i_sb;
        alu_r    = i_add | i_sub | i_slt | i_sll;
        known    = alu_r | i_jr | i_ori | i_lui | load | store | i_beq | i_j | i_jal;
        dec_jump = i_j | i_jr | !known;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   state <= imem_ready ? DECODE : FETCH;
                DECODE:  state <= dec_jump ? FETCH : i_jal ? WB : EXEC;
                EXEC:    state <= i_beq ? FETCH : (load | store) ? MEM : WB;
                MEM:     state <= !dmem_ready ? MEM : store ? FETCH : WB;
                WB:      state <= FETCH;
                default: state <= IDLE;
            endcase
    // Static datapath selects follow the IR in every state.
    always_comb begin
        ALUOp    = i_sub | i_beq ? 4'd1 : i_ori ? 4'd2 : i_slt ? 4'd3 : i_lui ? 4'd4 : i_sll ? 4'd5 : 4'd0;
        DMOp     = i_lb | i_sb ? 3'b001 : i_lbu ? 3'b101 : 3'b000;
        immExtOp = load | store | i_beq;
        BSel     = i_ori | i_lui | load | store;
        WRSel    = i_jal ? 2'd2 : alu_r ? 2'd1 : 2'd0;
        RFWDSel  = i_jal ? 2'd2 : load ? 2'd1 : 2'd0;
    end
    // PC moves only in the final cycle of an instruction so PC+4 is stable for the jal link.
    always_comb begin
        imem_req = state == FETCH;
        IRWE     = state == FETCH && imem_ready;
        dmem_req = state == MEM;
        DMWE     = state == MEM && store;
        RFWE     = state == WB;
        illegal  = state == DECODE && !known;
        PCWE     = (state == DECODE && dec_jump) || (state == EXEC && i_beq) ||
                   (state == MEM && dmem_ready && store) || state == WB;
        NPCOp    = state == DECODE && i_j ? 3'b010 :
                   state == DECODE && i_jr ? 3'b100 :
                   state == EXEC && i_beq && zero ? 3'b001 :
                   state == WB && i_jal ? 3'b011 : 3'b000;
    end
`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != IDLE) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (PCWE) instr_cnt <= instr_cnt + CNT_W'(1);
        end
`else
    assign cyc_cnt   = '0;
    assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench; expected per-cycle outputs are built from per-instruction cycle recipes.
module tb_mc_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [5:0]  opcode = '0, funct = '0;
    logic        zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, PCWE, IRWE, RFWE, DMWE, immExtOp, BSel, illegal;
    logic [2:0]  NPCOp, DMOp;
    logic [3:0]  ALUOp;
    logic [1:0]  WRSel, RFWDSel;
    logic [31:0] cyc_cnt, instr_cnt;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCWE(PCWE), .IRWE(IRWE), .RFWE(RFWE), .DMWE(DMWE), .NPCOp(NPCOp), .ALUOp(ALUOp),
        .DMOp(DMOp), .immExtOp(immExtOp), .BSel(BSel), .WRSel(WRSel), .RFWDSel(RFWDSel),
        .illegal(illegal), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // strobe vector order: {imem_req, IRWE, dmem_req, DMWE, RFWE, PCWE, illegal}
    localparam logic [6:0] IMR = 7'b1000000, IRW = 7'b0100000, DMR = 7'b0010000,
                           DMW = 7'b0001000, RFW = 7'b0000100, PCW = 7'b0000010, ILL = 7'b0000001;

    typedef struct {
        logic [6:0]  strb;
        logic [2:0]  npc;
        logic [12:0] stat;
        logic [5:0]  op, fn;
        logic        ir_r, dr_r, z;
        bit          idle;
    } cyc_t;

    cyc_t        q[$];
    int          lats[$];
    int          vectors = 0, fails = 0, lat = 0;
    logic [31:0] exp_cyc = 0, exp_ins = 0;
    int          cur_idx = 0;
    logic [5:0]  cur_op = 6'h00, cur_fn = 6'h20;
    logic [7:0]  last_pc;

    // Instruction table: 0 add,1 sub,2 slt,3 sll,4 jr,5 ori,6 lui,7 lw,8 lb,9 lbu,10 sw,11 sb,12 beq,13 j,14 jal,15/16 illegal
    function automatic logic [5:0] op_of(int i);
        case (i)
            0, 1, 2, 3, 4, 16: return 6'h00;
            5: return 6'h0d;  6: return 6'h0f;  7: return 6'h23;  8: return 6'h20;
            9: return 6'h24; 10: return 6'h2b; 11: return 6'h28; 12: return 6'h04;
            13: return 6'h02; 14: return 6'h03;
            default: return 6'h3f;
        endcase
    endfunction

    function automatic logic [5:0] fn_of(int i);
        case (i)
            0: return 6'h20; 1: return 6'h22; 2: return 6'h2a; 3: return 6'h00;
            4: return 6'h08; 16: return 6'h3f;
            default: return 6'($urandom);
        endcase
    endfunction

    // {ALUOp, DMOp, immExtOp, BSel, WRSel, RFWDSel}
    function automatic logic [12:0] stat_of(int i);
        case (i)
            0:  return {4'd0, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0};
            1:  return {4'd1, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0};
            2:  return {4'd3, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0};
            3:  return {4'd5, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0};
            5:  return {4'd2, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0};
            6:  return {4'd4, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0};
            7:  return {4'd0, 3'd0, 1'b1, 1'b1, 2'd0, 2'd1};
            8:  return {4'd0, 3'd1, 1'b1, 1'b1, 2'd0, 2'd1};
            9:  return {4'd0, 3'd5, 1'b1, 1'b1, 2'd0, 2'd1};
            10: return {4'd0, 3'd0, 1'b1, 1'b1, 2'd0, 2'd0};
            11: return {4'd0, 3'd1, 1'b1, 1'b1, 2'd0, 2'd0};
            12: return {4'd1, 3'd0, 1'b1, 1'b0, 2'd0, 2'd0};
            14: return {4'd0, 3'd0, 1'b0, 1'b0, 2'd2, 2'd2};
            default: return 13'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ready < 0 means random noise on a line nobody should be listening to
    task automatic push(input logic [6:0] s, input logic [2:0] n, input int ir, input int dr, input int z, input bit idle);
        cyc_t c;
        c.strb = s; c.npc = n; c.stat = stat_of(cur_idx); c.op = cur_op; c.fn = cur_fn;
        c.ir_r = ir < 0 ? 1'($urandom) : 1'(ir);
        c.dr_r = dr < 0 ? 1'($urandom) : 1'(dr);
        c.z    = z < 0 ? 1'($urandom) : 1'(z);
        c.idle = idle;
        q.push_back(c);
    endtask

    task automatic push_instr(input int idx, input int wi, input int wd, input bit z);
        for (int k = 0; k < wi; k++) push(IMR, 3'd0, 0, -1, -1, 0);
        push(IMR | IRW, 3'd0, 1, -1, -1, 0);
        cur_idx = idx; cur_op = op_of(idx); cur_fn = fn_of(idx);
        if (idx == 13 || idx == 4) push(PCW, idx == 13 ? 3'b010 : 3'b100, -1, -1, -1, 0);
        else if (idx >= 15) push(PCW | ILL, 3'd0, -1, -1, -1, 0);
        else if (idx == 14) begin
            push(7'd0, 3'd0, -1, -1, -1, 0);
            push(RFW | PCW, 3'b011, -1, -1, -1, 0);
        end else if (idx == 12) begin
            push(7'd0, 3'd0, -1, -1, -1, 0);
            push(PCW, z ? 3'b001 : 3'b000, -1, -1, int'(z), 0);
        end else begin
            push(7'd0, 3'd0, -1, -1, -1, 0);
            push(7'd0, 3'd0, -1, -1, -1, 0);
            if (idx >= 7 && idx <= 11) begin
                for (int k = 0; k < wd; k++) push(idx >= 10 ? DMR | DMW : DMR, 3'd0, -1, 0, -1, 0);
                push(idx >= 10 ? DMR | DMW | PCW : DMR, 3'd0, -1, 1, -1, 0);
            end
            if (idx < 10) push(RFW | PCW, 3'd0, -1, -1, -1, 0);
        end
    endtask

    // Called #1 after a rising edge; each entry covers one full clock cycle.
    task automatic run();
        while (q.size() > 0) begin
            cyc_t c = q.pop_front();
            opcode = c.op; funct = c.fn; zero = c.z; imem_ready = c.ir_r; dmem_ready = c.dr_r;
            @(negedge clk);
            chk("strobes", {imem_req, IRWE, dmem_req, DMWE, RFWE, PCWE, illegal}, c.strb);
            chk("NPCOp", NPCOp, c.npc);
            chk("static", {ALUOp, DMOp, immExtOp, BSel, WRSel, RFWDSel}, c.stat);
`ifdef MC_CTRL_PERF_EN
            chk("cyc_cnt", cyc_cnt, exp_cyc);
            chk("instr_cnt", instr_cnt, exp_ins);
`else
            chk("cyc_cnt", cyc_cnt, 0);
            chk("instr_cnt", instr_cnt, 0);
`endif
            if (!c.idle) begin lat++; exp_cyc++; end
            if (c.strb[1]) exp_ins++;
            if (PCWE) begin
                lats.push_back(lat);
                lat = 0;
                last_pc = {WRSel, RFWDSel, RFWE, NPCOp};
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {imem_req, IRWE, dmem_req, DMWE, RFWE, PCWE, illegal, NPCOp}, 10'd0);
        chk({name, "_cnt"}, {cyc_cnt, instr_cnt}, 64'd0);
    endtask

    initial begin
        int exp_lat[7] = '{4, 4, 5, 4, 3, 2, 3};
        opcode = cur_op; funct = cur_fn;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        // ori, add, lw, sw, beq taken, j, jal at zero wait
        push(7'd0, 3'd0, -1, -1, -1, 1);
        push_instr(5, 0, 0, 0); push_instr(0, 0, 0, 0); push_instr(7, 0, 0, 0); push_instr(10, 0, 0, 0);
        push_instr(12, 0, 0, 1); push_instr(13, 0, 0, 0); push_instr(14, 0, 0, 0);
        run();
        chk("lat_count", lats.size(), 7);
        for (int i = 0; i < 7 && i < lats.size(); i++) chk($sformatf("lat%0d", i), lats[i], exp_lat[i]);
        chk("jal_wb", last_pc, {2'd2, 2'd2, 1'b1, 3'b011});
        // beq not taken, 3-cycle fetch stall, sb with 2 dmem waits, both illegal forms
        lats.delete();
        push_instr(12, 0, 0, 0); push_instr(0, 3, 0, 0); push_instr(11, 0, 2, 0);
        push_instr(15, 0, 0, 0); push_instr(16, 0, 0, 0);
        run();
        chk("sb_lat", lats.size() > 2 ? lats[2] : -1, 6);
        for (int n = 0; n < 150; n++)
            push_instr($urandom_range(0, 16), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        run();
        // lw parked in MEM, then asynchronous reset with a late dmem_ready
        push_instr(7, 0, 5, 0);
        repeat (5) void'(q.pop_back());
        run();
        dmem_ready = 1'b0;
        #1 chk("pre_rst_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        #1 chk_quiet("async_rst");
        dmem_ready = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        chk_quiet("rst_hold");
        @(posedge clk); #1 rst_n = 1'b1;
        exp_cyc = 0; exp_ins = 0; lat = 0;
        push(7'd0, 3'd0, -1, -1, -1, 1);
        for (int n = 0; n < 20; n++)
            push_instr($urandom_range(0, 16), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
